// File: rtl/multicycle_control_if.sv
// multicycle_control_if: memory-port handshake between the sequencer (master) and the shared memory (slave)
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;
  modport master (output mem_req, mem_we, mem_addr_sel, input mem_ready);
  modport slave (input mem_req, mem_we, mem_addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: RV32I multi-cycle sequencer FSM with retire counter; ILLEGAL_TRAP_EN selects halt-on-illegal-opcode
module multicycle_control (
  input  logic                        clk,
  input  logic                        rst_n,
  multicycle_control_if.master        mem,
  input  logic [6:0]                  opcode,
  input  logic                        branch_taken,
  output logic                        ir_write,
  output logic                        pc_write,
  output logic                        pc_src,
  output logic [1:0]                  alu_src_a,
  output logic [1:0]                  alu_src_b,
  output logic [1:0]                  alu_op,
  output logic                        reg_write,
  output logic [1:0]                  wb_sel,
  output logic                        retire,
  output logic [31:0]                 instret,
  output logic                        illegal,
  output logic [3:0]                  state
);
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  typedef enum logic [3:0] {
    S_RESET = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEM_ADDR = 4'd3,
    S_MEM_RD = 4'd4, S_WB_MEM = 4'd5, S_MEM_WR = 4'd6, S_EXEC_R = 4'd7,
    S_EXEC_I = 4'd8, S_LUI = 4'd9, S_WB_ALU = 4'd10, S_BRANCH = 4'd11,
    S_JAL = 4'd12, S_HALT = 4'd13
  } state_t;
  // state-only part of the output decode; pc_write/retire hold just the unconditional terms
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       pc_write;
    logic       retire;
  } moore_t;
  state_t r_state;
  state_t w_next;
  state_t w_dispatch;
  moore_t r_out;
  logic   w_known;
  logic   w_nop_retire;
  logic [31:0] r_instret;
  function automatic moore_t f_moore(state_t s);
    moore_t m;
    m = '0;
    case (s)
      S_FETCH: begin
        m.mem_req   = 1'b1;
        m.alu_src_a = 2'b01;
        m.alu_src_b = 2'b10;
      end
      S_DECODE: begin
        m.alu_src_a = 2'b10;
        m.alu_src_b = 2'b01;
      end
      S_MEM_ADDR: m.alu_src_b = 2'b01;
      S_MEM_RD: begin
        m.mem_req      = 1'b1;
        m.mem_addr_sel = 1'b1;
      end
      S_WB_MEM: begin
        m.reg_write = 1'b1;
        m.wb_sel    = 2'b01;
        m.retire    = 1'b1;
      end
      S_MEM_WR: begin
        m.mem_req      = 1'b1;
        m.mem_we       = 1'b1;
        m.mem_addr_sel = 1'b1;
      end
      S_EXEC_R: m.alu_op = 2'b10;
      S_EXEC_I: begin
        m.alu_src_b = 2'b01;
        m.alu_op    = 2'b10;
      end
      S_LUI: begin
        m.alu_src_a = 2'b11;
        m.alu_src_b = 2'b01;
        m.alu_op    = 2'b11;
      end
      S_WB_ALU: begin
        m.reg_write = 1'b1;
        m.retire    = 1'b1;
      end
      S_BRANCH: begin
        m.alu_op = 2'b01;
        m.pc_src = 1'b1;
        m.retire = 1'b1;
      end
      S_JAL: begin
        m.pc_src    = 1'b1;
        m.pc_write  = 1'b1;
        m.reg_write = 1'b1;
        m.wb_sel    = 2'b10;
        m.retire    = 1'b1;
      end
      default: m = '0;
    endcase
    return m;
  endfunction
  // opcode dispatch out of DECODE; unknown opcodes trap or fall through as a NOP
  always_comb begin
    w_known    = 1'b1;
    w_dispatch = S_FETCH;
    case (opcode)
      OP_R:              w_dispatch = S_EXEC_R;
      OP_I:              w_dispatch = S_EXEC_I;
      OP_LOAD, OP_STORE: w_dispatch = S_MEM_ADDR;
      OP_BR:             w_dispatch = S_BRANCH;
      OP_JAL:            w_dispatch = S_JAL;
      OP_LUI:            w_dispatch = S_LUI;
      default: begin
        w_known = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        w_dispatch = S_HALT;
`else
        w_dispatch = S_FETCH;
`endif
      end
    endcase
  end
  // next-state: memory states wait on mem_ready, everything else advances unconditionally
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET:    w_next = S_FETCH;
      S_FETCH:    w_next = mem.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   w_next = w_dispatch;
      S_MEM_ADDR: w_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next = mem.mem_ready ? S_WB_MEM : S_MEM_RD;
      S_WB_MEM:   w_next = S_FETCH;
      S_MEM_WR:   w_next = mem.mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R, S_EXEC_I, S_LUI: w_next = S_WB_ALU;
      S_WB_ALU, S_BRANCH, S_JAL: w_next = S_FETCH;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_RESET;
    endcase
  end
  // state register with outputs pre-decoded from the next state so they leave flops directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RESET;
      r_out   <= '0;
    end else begin
      r_state <= w_next;
      r_out   <= f_moore(w_next);
    end
  end
`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;
  assign w_nop_retire = 1'b0;
  // sticky illegal flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_illegal <= 1'b0;
    else if (r_state == S_DECODE && !w_known) r_illegal <= 1'b1;
  end
  assign illegal = r_illegal;
`else
  assign w_nop_retire = (r_state == S_DECODE) && !w_known;
  assign illegal      = 1'b0;
`endif
  assign mem.mem_req      = r_out.mem_req;
  assign mem.mem_we       = r_out.mem_we;
  assign mem.mem_addr_sel = r_out.mem_addr_sel;
  assign pc_src           = r_out.pc_src;
  assign alu_src_a        = r_out.alu_src_a;
  assign alu_src_b        = r_out.alu_src_b;
  assign alu_op           = r_out.alu_op;
  assign reg_write        = r_out.reg_write;
  assign wb_sel           = r_out.wb_sel;
  assign ir_write         = (r_state == S_FETCH) && mem.mem_ready;
  assign pc_write         = r_out.pc_write || ir_write || ((r_state == S_BRANCH) && branch_taken);
  assign retire           = r_out.retire || ((r_state == S_MEM_WR) && mem.mem_ready) || w_nop_retire;
  assign state            = r_state;
  // retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_instret <= '0;
    else if (retire) r_instret <= r_instret + 32'd1;
  end
  assign instret = r_instret;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed instruction sequences checked cycle by cycle against an instruction-level model
module tb_multicycle_control;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011, OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_LUI = 7'b0110111;
  localparam logic [3:0] S_RST = 4'd0, S_F = 4'd1, S_D = 4'd2, S_MA = 4'd3, S_MR = 4'd4, S_WBM = 4'd5, S_MW = 4'd6;
  localparam logic [3:0] S_ER = 4'd7, S_EI = 4'd8, S_LUI = 4'd9, S_WBA = 4'd10, S_BR = 4'd11, S_JAL = 4'd12, S_HALT = 4'd13;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic branch_taken = 1'b0;
  logic ir_write, pc_write, pc_src, reg_write, retire, illegal;
  logic [1:0] alu_src_a, alu_src_b, alu_op, wb_sel;
  logic [31:0] instret;
  logic [3:0] state;
  int errors = 0, checks = 0, rcyc = 0, ncyc = 0, rw_cnt = 0, rw_cyc = -1, ret_cnt = 0, n;
  logic [31:0] m_instret = 32'd0;
  logic m_illegal = 1'b0;
  logic [6:0] cur_op = OP_R;
  logic cur_tkn = 1'b0;
  multicycle_control_if mif ();
  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .mem(mif), .opcode(opcode), .branch_taken(branch_taken),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel),
    .retire(retire), .instret(instret), .illegal(illegal), .state(state)
  );
  always #5 clk = ~clk;
  initial mif.mem_ready = 1'b0;
  function automatic logic known(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_LUI};
  endfunction
  // expected bundle {req,we,asel,irw,pcw,pcs,src_a,src_b,alu_op,reg_write,wb_sel,retire} from the state table
  function automatic logic [16:0] exp_outs(input logic [3:0] s, input logic rdy, input logic tkn, input logic [6:0] op);
    logic req, we, asel, irw, pcw, pcs, rw, ret;
    logic [1:0] sa, sb, aop, wb;
    {req, we, asel, irw, pcw, pcs, rw, ret} = '0;
    {sa, sb, aop, wb} = '0;
    case (s)
      S_F:   begin req = 1; sa = 2'b01; sb = 2'b10; irw = rdy; pcw = rdy; end
      S_D:   begin sa = 2'b10; sb = 2'b01; ret = !known(op) && !TRAP; end
      S_MA:  sb = 2'b01;
      S_MR:  begin req = 1; asel = 1; end
      S_WBM: begin rw = 1; wb = 2'b01; ret = 1; end
      S_MW:  begin req = 1; we = 1; asel = 1; ret = rdy; end
      S_ER:  aop = 2'b10;
      S_EI:  begin sb = 2'b01; aop = 2'b10; end
      S_LUI: begin sa = 2'b11; sb = 2'b01; aop = 2'b11; end
      S_WBA: begin rw = 1; ret = 1; end
      S_BR:  begin aop = 2'b01; pcs = 1; pcw = tkn; ret = 1; end
      S_JAL: begin pcs = 1; pcw = 1; rw = 1; wb = 2'b10; ret = 1; end
      default: ;
    endcase
    return {req, we, asel, irw, pcw, pcs, sa, sb, aop, rw, wb, ret};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h, required %h", name, $time, act, req);
    end
  endtask
  // one clock: drive inputs after the edge, compare everything on the falling edge, advance the model
  task automatic cyc(input logic [3:0] s, input logic rdy, input logic rst);
    logic [16:0] e;
    @(posedge clk);
    #1;
    rst_n = !rst;
    mif.mem_ready = rdy;
    branch_taken = cur_tkn;
    opcode = cur_op;
    rcyc = rst ? -1 : rcyc + 1;
    ncyc++;
    @(negedge clk);
    if (rst) begin
      m_instret = 32'd0;
      m_illegal = 1'b0;
    end
    e = exp_outs(s, rdy, cur_tkn, cur_op);
    chk("state", {28'd0, state}, {28'd0, s});
    chk("outputs", {15'd0, mif.mem_req, mif.mem_we, mif.mem_addr_sel, ir_write, pc_write, pc_src,
        alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, retire}, {15'd0, e});
    chk("instret", instret, m_instret);
    chk("illegal", {31'd0, illegal}, {31'd0, m_illegal});
    if (reg_write) begin rw_cnt++; rw_cyc = rcyc; end
    if (retire) ret_cnt++;
    if (e[0]) m_instret = m_instret + 32'd1;
    if (s == S_D && !known(cur_op) && TRAP) m_illegal = 1'b1;
  endtask
  task automatic do_reset();
    cyc(S_RST, 1'b0, 1'b1);
    cyc(S_RST, 1'b1, 1'b0);
  endtask
  // expand one instruction into its cycle sequence; fw/mw are memory wait cycles, pre preloads the counter
  task automatic instr(input logic [6:0] op, input int fw, input int mw, input logic tkn, input logic pre, output int len);
    int start;
    start = ncyc;
    cur_op = op;
    cur_tkn = tkn;
    repeat (fw) cyc(S_F, 1'b0, 1'b0);
    cyc(S_F, 1'b1, 1'b0);
    cyc(S_D, 1'b1, 1'b0);
    if (pre) begin
      force dut.r_instret = 32'hFFFF_FFFF;
      #1;
      release dut.r_instret;
      m_instret = 32'hFFFF_FFFF;
    end
    case (op)
      OP_R:   begin cyc(S_ER, 1'b1, 1'b0); cyc(S_WBA, 1'b1, 1'b0); end
      OP_I:   begin cyc(S_EI, 1'b1, 1'b0); cyc(S_WBA, 1'b1, 1'b0); end
      OP_LUI: begin cyc(S_LUI, 1'b1, 1'b0); cyc(S_WBA, 1'b1, 1'b0); end
      OP_LD: begin
        cyc(S_MA, 1'b1, 1'b0);
        repeat (mw) cyc(S_MR, 1'b0, 1'b0);
        cyc(S_MR, 1'b1, 1'b0);
        cyc(S_WBM, 1'b1, 1'b0);
      end
      OP_ST: begin
        cyc(S_MA, 1'b1, 1'b0);
        repeat (mw) cyc(S_MW, 1'b0, 1'b0);
        cyc(S_MW, 1'b1, 1'b0);
      end
      OP_BR:  cyc(S_BR, 1'b1, 1'b0);
      OP_JAL: cyc(S_JAL, 1'b1, 1'b0);
      default: begin
`ifdef ILLEGAL_TRAP_EN
        repeat (3) cyc(S_HALT, 1'b1, 1'b0);
`endif
      end
    endcase
    len = ncyc - start;
  endtask
  initial begin
    do_reset();
    chk("reset_state", {28'd0, state}, 32'd0);
    chk("reset_instret", instret, 32'd0);
    rw_cnt = 0;
    instr(OP_R, 0, 0, 1'b0, 1'b0, n);
    chk("add_len", n, 4);
    cyc(S_F, 1'b0, 1'b0);
    chk("add_instret", instret, 32'd1);
    chk("add_regwrite_pulses", rw_cnt, 1);
    do_reset();
    rw_cnt = 0;
    instr(OP_LD, 3, 3, 1'b0, 1'b0, n);
    chk("lw_len", n, 11);
    chk("lw_regwrite_cycle", rw_cyc, 11);
    cyc(S_F, 1'b0, 1'b0);
    chk("lw_instret", instret, 32'd1);
    instr(OP_BR, 0, 0, 1'b1, 1'b0, n);
    chk("beq_taken_len", n, 3);
    instr(OP_BR, 0, 0, 1'b0, 1'b0, n);
    chk("beq_not_taken_len", n, 3);
    instr(OP_I, 0, 0, 1'b0, 1'b0, n);
    chk("itype_len", n, 4);
    instr(OP_LUI, 0, 0, 1'b0, 1'b0, n);
    chk("lui_len", n, 4);
    instr(OP_ST, 0, 0, 1'b0, 1'b0, n);
    chk("sw_len", n, 4);
    instr(OP_LD, 0, 0, 1'b0, 1'b0, n);
    chk("lw_fast_len", n, 5);
    instr(OP_ST, 1, 2, 1'b0, 1'b0, n);
    chk("sw_wait_len", n, 7);
    instr(OP_JAL, 0, 0, 1'b0, 1'b0, n);
    chk("jal_len", n, 3);
    instr(OP_JAL, 0, 0, 1'b0, 1'b1, n);
    cyc(S_F, 1'b0, 1'b0);
    chk("wrap_instret", instret, 32'd0);
    ret_cnt = 0;
    rw_cnt = 0;
    cur_op = OP_ST;
    cyc(S_F, 1'b1, 1'b0);
    cyc(S_D, 1'b1, 1'b0);
    cyc(S_MA, 1'b1, 1'b0);
    cyc(S_MW, 1'b0, 1'b0);
    cyc(S_MW, 1'b0, 1'b0);
    cyc(S_RST, 1'b0, 1'b1);
    chk("abort_mem_req", {31'd0, mif.mem_req}, 32'd0);
    cyc(S_RST, 1'b1, 1'b0);
    cyc(S_F, 1'b0, 1'b0);
    chk("abort_retires", ret_cnt, 0);
    chk("abort_regwrites", rw_cnt, 0);
    ret_cnt = 0;
    instr(7'b0000000, 0, 0, 1'b0, 1'b0, n);
`ifdef ILLEGAL_TRAP_EN
    chk("illegal_len", n, 5);
    chk("illegal_flag", {31'd0, illegal}, 32'd1);
    chk("illegal_halt_state", {28'd0, state}, 32'd13);
    chk("illegal_no_retire", ret_cnt, 0);
    do_reset();
    chk("illegal_cleared", {31'd0, illegal}, 32'd0);
    instr(OP_R, 0, 0, 1'b0, 1'b0, n);
    chk("post_halt_add_len", n, 4);
`else
    chk("illegal_len", n, 2);
    chk("illegal_nop_retire", ret_cnt, 1);
    cyc(S_F, 1'b0, 1'b0);
    chk("illegal_next_fetch", {28'd0, state}, 32'd1);
    chk("illegal_nop_instret", instret, 32'd1);
    chk("illegal_flag_tied", {31'd0, illegal}, 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the RV32I core: a Moore/Mealy FSM that steps one instruction through fetch, decode, execute, memory and writeback over several cycles. It drives the select and strobe lines of a shared-ALU, single-memory-port datapath and handshakes with that memory port. It also counts retired instructions. It replaces per-cycle opcode decoding when the core runs in multi-cycle mode.

## Interface
- No parameters.
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  7  instr[6:0] from the instruction register, valid from DECODE onward
- branch_taken  in  1  branch-unit compare result (funct3-evaluated), valid in BRANCH
- mem_ready  in  1  memory port completion strobe
- mem_req  out  1  memory access request
- mem_we  out  1  write enable qualifying mem_req
- mem_addr_sel  out  1  0 = PC, 1 = ALUOut
- ir_write  out  1  load IR and old_pc register
- pc_write  out  1  load PC
- pc_src  out  1  0 = live ALU result, 1 = ALUOut register
- alu_src_a  out  2  00 rs1, 01 PC, 10 old_pc, 11 zero
- alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
- alu_op  out  2  00 add, 01 branch compare/sub, 10 funct-decoded, 11 pass B
- reg_write  out  1  register file write strobe
- wb_sel  out  2  00 ALUOut, 01 MDR, 10 PC
- retire  out  1  one-cycle pulse per completed instruction
- instret  out  32  retired-instruction count
- illegal  out  1  sticky illegal-opcode flag
- state  out  4  current state, debug

## Operation
- States and codes: RESET=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, WB_MEM=5, MEM_WR=6, EXEC_R=7, EXEC_I=8, LUI=9, WB_ALU=10, BRANCH=11, JAL=12, HALT=13.
- Unlisted outputs are 0 in every state.
- RESET: all outputs 0. Next state is FETCH.
- FETCH: mem_req=1, mem_addr_sel=0, alu_src_a=01, alu_src_b=10, alu_op=00, pc_src=0.
  - ir_write and pc_write are asserted only when mem_ready=1. DECODE follows on that cycle.
  - Otherwise the FSM stays in FETCH.
- DECODE: alu_src_a=10, alu_src_b=01, alu_op=00 (branch/JAL target into ALUOut). Dispatch on opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 0110111 → LUI
  - other → see Configuration
- EXEC_R: src_a=00, src_b=00, alu_op=10.
- EXEC_I: src_a=00, src_b=01, alu_op=10.
- LUI: src_a=11, src_b=01, alu_op=11.
- EXEC_R, EXEC_I and LUI all → WB_ALU.
- WB_ALU: reg_write=1, wb_sel=00, retire=1. Next state FETCH.
- MEM_ADDR: src_a=00, src_b=01, alu_op=00. Load → MEM_RD; store → MEM_WR.
- MEM_RD: mem_req=1, mem_addr_sel=1. Held until mem_ready, then → WB_MEM.
- WB_MEM: reg_write=1, wb_sel=01, retire=1. Next state FETCH.
- MEM_WR: mem_req=1, mem_we=1, mem_addr_sel=1. On mem_ready: retire=1, → FETCH.
- BRANCH: src_a=00, src_b=00, alu_op=01, pc_src=1, pc_write=branch_taken, retire=1. Next state FETCH.
- JAL: pc_src=1, pc_write=1, reg_write=1, wb_sel=10 (PC already holds old_pc+4), retire=1. Next state FETCH.
- Output decode: all outputs are a function of state only, except these terms gated combinationally by an input:
  - ir_write and pc_write in FETCH (gated by mem_ready)
  - pc_write in BRANCH (gated by branch_taken)
  - retire in MEM_WR (gated by mem_ready)
- instret: increments by 1 on every cycle with retire=1. 0xFFFFFFFF wraps to 0x00000000.

## Timing
- Reset is asynchronous and active-low. On reset: state=RESET, instret=0, illegal=0, all strobes 0.
- First mem_req appears in the second cycle after rst_n rises.
- Handshake:
  - mem_req, mem_we and mem_addr_sel stay stable until the cycle mem_ready=1 is sampled.
  - mem_ready is ignored whenever mem_req=0.
  - Each accepted mem_ready ends exactly one request.
- Latency in cycles, with a memory that returns mem_ready in the same cycle (add wait cycles per access):
  - branch and JAL: 3
  - R-type, I-type, LUI and store: 4
  - load: 5
- Reset asserted mid-access drops mem_req immediately. The in-flight instruction is abandoned with no retire and no register write.
- Retire and a count wrap in the same cycle produce instret=0. retire still pulses.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An unknown opcode in DECODE → HALT and sets illegal=1.
  - HALT drives all strobes to 0 and is left only by reset.
- ILLEGAL_TRAP_EN undefined:
  - An unknown opcode in DECODE → FETCH with retire=1, so it behaves as a NOP.
  - illegal is tied to 0 and HALT is unreachable.

## Test plan
- Reset release, mem_ready tied 1, instruction ADD (opcode 0110011) → state sequence 0,1,2,7,10,1. reg_write pulses once. instret=1.
- LW with mem_ready delayed 3 cycles in both FETCH and MEM_RD → mem_req held stable throughout. reg_write asserts with wb_sel=01 on cycle 11 after reset. instret=1.
- BEQ with branch_taken=1 and then branch_taken=0 → pc_write=1 with pc_src=1 in the first BRANCH cycle; pc_write=0 in the second. Each takes 3 cycles.
- Preload instret to 0xFFFFFFFF via back-to-back JALs (force the counter in simulation) → next retire gives instret=0x00000000.
- rst_n pulled low during MEM_WR wait → mem_req=0 in the same cycle. No retire. State=RESET, then FETCH.
- Opcode 0000000:
  - with ILLEGAL_TRAP_EN → illegal=1, state=13, no further mem_req.
  - without it → retire=1 and the next FETCH follows.
